// File: rtl/video_box_filter.sv
// ---------------------------------------------------------------------------
// video_box_filter
//   Streaming mean (box) filter in the pixel clock domain. It sits between the
//   timing/pattern source and the DVI transmitter. Three run-time modes:
//   bypass, 1x3 horizontal mean, and causal 3x3 mean. In 3x3 mode the window
//   covers rows y-2..y and cols x-2..x, clamped at the top and left edges.
//   Input to output latency is a fixed 4 cycles in every mode.
//
// Ports
//   pix_clk    in   pixel clock (only clock)
//   rstn       in   async active-low reset, synchronous release expected
//   mode_in    in   2'b00 bypass, 2'b01 1x3, 2'b10 3x3, 2'b11 bypass
//   vs_in      in   vsync, active high, rising edge = frame start
//   hs_in      in   hsync, delayed only
//   de_in      in   data enable
//   pixel_in   in   CHANNELS*COLOR_DEPTH pixel, ch0 in LSBs
//   vs_out     out  vs_in delayed 4 cycles
//   hs_out     out  hs_in delayed 4 cycles
//   de_out     out  de_in delayed 4 cycles
//   pixel_out  out  filtered pixel, zero when de_out=0
//   frame_mode out  mode latched at the last vs_in rising edge
// ---------------------------------------------------------------------------
module video_box_filter #(
   parameter int COLOR_DEPTH = 8,
   parameter int CHANNELS    = 3,
   parameter int H_ACT       = 1920,
   parameter int X_BITS      = 12,
   parameter int Y_BITS      = 12
) (
   input  logic                            pix_clk,
   input  logic                            rstn,
   input  logic [1:0]                      mode_in,
   input  logic                            vs_in,
   input  logic                            hs_in,
   input  logic                            de_in,
   input  logic [CHANNELS*COLOR_DEPTH-1:0] pixel_in,
   output logic                            vs_out,
   output logic                            hs_out,
   output logic                            de_out,
   output logic [CHANNELS*COLOR_DEPTH-1:0] pixel_out,
   output logic [1:0]                      frame_mode
);

   localparam int PW    = CHANNELS * COLOR_DEPTH;
   localparam int SW    = COLOR_DEPTH + 4;
   localparam int MW    = SW + 8;
   localparam int AW    = $clog2(H_ACT);
   localparam int SHIFT = 9;
   localparam logic [X_BITS-1:0] COL_MAX = X_BITS'(H_ACT - 1);
   localparam logic [Y_BITS-1:0] ROW_MAX = '1;
   localparam logic [MW-1:0]     PIX_MAX = MW'((2 ** COLOR_DEPTH) - 1);
   localparam logic [1:0] MODE_H3 = 2'b01;
   localparam logic [1:0] MODE_B9 = 2'b10;
   // position classes used for edge clamping: first, second, or any later index
   localparam logic [1:0] CLS_0 = 2'd0;
   localparam logic [1:0] CLS_1 = 2'd1;
   localparam logic [1:0] CLS_N = 2'd2;

   // Mean of a window sum: multiply by a reciprocal, truncate, saturate.
   function automatic logic [COLOR_DEPTH-1:0] mean_scale(input logic [SW-1:0] s,
                                                         input logic [7:0]    k);
      logic [MW-1:0] prod;
      prod = (MW'(s) * MW'(k)) >> SHIFT;
      if (prod > PIX_MAX) begin
         return '1;
      end else begin
         return prod[COLOR_DEPTH-1:0];
      end
   endfunction

   logic              vs_d_r, de_d_r;
   logic              vs_rise_s, de_rise_s, de_fall_s;
   logic [X_BITS-1:0] col_r, col_s;
   logic [Y_BITS-1:0] row_r, row_s;
   logic [1:0]        mode_s, row_cls_s, col_cls_s;

   logic [PW-1:0] lb0_mem [0:H_ACT-1];
   logic [PW-1:0] lb1_mem [0:H_ACT-1];
   logic [PW-1:0] lb0_rd_r, lb1_rd_r;
   logic [AW-1:0] addr_s;

   logic [PW-1:0] pix_1_r;
   logic [1:0]    row_cls_1_r, col_cls_1_r, mode_1_r, mode_2_r, mode_3_r;
   logic [2:0]    sync_1_r, sync_2_r, sync_3_r;   // {vs, hs, de}
   logic [PW-1:0] v_s   [0:2];
   logic [PW-1:0] tap_r [0:2][0:2];               // [row y-r][col x-k]
   logic [SW-1:0] sum9_s [0:CHANNELS-1];
   logic [SW-1:0] sum3_s [0:CHANNELS-1];
   logic [SW-1:0] sum9_r [0:CHANNELS-1];
   logic [SW-1:0] sum3_r [0:CHANNELS-1];
   logic [PW-1:0] byp_3_r;
   logic [PW-1:0] filt_s;

   // Edge detection and the position of the pixel currently on the input.
   // A frame start takes priority for the row; a line start zeroes the column.
   always_comb begin
      vs_rise_s = vs_in & ~vs_d_r;
      de_rise_s = de_in & ~de_d_r;
      de_fall_s = ~de_in & de_d_r;
      col_s     = de_rise_s ? '0 : col_r;
      row_s     = vs_rise_s ? '0 : row_r;
      mode_s    = vs_rise_s ? mode_in : frame_mode;
      addr_s    = col_s[AW-1:0];
      if (row_s == '0) begin
         row_cls_s = CLS_0;
      end else if (row_s == Y_BITS'(1)) begin
         row_cls_s = CLS_1;
      end else begin
         row_cls_s = CLS_N;
      end
      if (col_s == '0) begin
         col_cls_s = CLS_0;
      end else if (col_s == X_BITS'(1)) begin
         col_cls_s = CLS_1;
      end else begin
         col_cls_s = CLS_N;
      end
   end

   // Frame/line counters, edge history and the per-frame mode latch.
   always_ff @(posedge pix_clk or negedge rstn) begin
      if (!rstn) begin
         vs_d_r     <= 1'b0;
         de_d_r     <= 1'b0;
         col_r      <= '0;
         row_r      <= '0;
         frame_mode <= 2'b00;
      end else begin
         vs_d_r <= vs_in;
         de_d_r <= de_in;
         if (vs_rise_s) begin
            frame_mode <= mode_in;
         end
         if (de_in) begin
            col_r <= (col_s == COL_MAX) ? col_s : col_s + X_BITS'(1);
         end
         if (vs_rise_s) begin
            row_r <= '0;
         end else if (de_fall_s && (row_r != ROW_MAX)) begin
            row_r <= row_r + Y_BITS'(1);
         end
      end
   end

   // Cascaded line buffers, read-before-write at the column address.
   // Storage is deliberately not reset; the top clamp hides stale rows.
   always_ff @(posedge pix_clk) begin
      if (de_in) begin
         lb0_rd_r        <= lb0_mem[addr_s];
         lb1_rd_r        <= lb1_mem[addr_s];
         lb0_mem[addr_s] <= pixel_in;
         lb1_mem[addr_s] <= lb0_mem[addr_s];
      end
   end

   // Stage 1: current pixel, clamp classes, sync bits and mode.
   always_ff @(posedge pix_clk or negedge rstn) begin
      if (!rstn) begin
         pix_1_r     <= '0;
         row_cls_1_r <= CLS_0;
         col_cls_1_r <= CLS_0;
         mode_1_r    <= 2'b00;
         sync_1_r    <= 3'b000;
      end else begin
         pix_1_r     <= pixel_in;
         row_cls_1_r <= row_cls_s;
         col_cls_1_r <= col_cls_s;
         mode_1_r    <= mode_s;
         sync_1_r    <= {vs_in, hs_in, de_in};
      end
   end

   // Vertical taps with the top clamp applied.
   always_comb begin
      v_s[0] = pix_1_r;
      if (row_cls_1_r == CLS_0) begin
         v_s[1] = pix_1_r;
      end else begin
         v_s[1] = lb0_rd_r;
      end
      if (row_cls_1_r == CLS_N) begin
         v_s[2] = lb1_rd_r;
      end else begin
         v_s[2] = v_s[1];
      end
   end

   // Stage 2: horizontal shift registers with the left clamp applied.
   always_ff @(posedge pix_clk or negedge rstn) begin
      if (!rstn) begin
         for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
               tap_r[r][k] <= '0;
            end
         end
         mode_2_r <= 2'b00;
         sync_2_r <= 3'b000;
      end else begin
         for (int r = 0; r < 3; r++) begin
            tap_r[r][0] <= v_s[r];
            case (col_cls_1_r)
               CLS_0: begin
                  tap_r[r][1] <= v_s[r];
                  tap_r[r][2] <= v_s[r];
               end
               CLS_1: begin
                  tap_r[r][1] <= tap_r[r][0];
                  tap_r[r][2] <= tap_r[r][0];
               end
               default: begin
                  tap_r[r][1] <= tap_r[r][0];
                  tap_r[r][2] <= tap_r[r][1];
               end
            endcase
         end
         mode_2_r <= mode_1_r;
         sync_2_r <= sync_1_r;
      end
   end

   // Adder tree: 9-tap and current-row 3-tap sums per channel.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         sum9_s[c] = '0;
         sum3_s[c] = '0;
         for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
               sum9_s[c] = sum9_s[c] + SW'(tap_r[r][k][c*COLOR_DEPTH +: COLOR_DEPTH]);
            end
         end
         for (int k = 0; k < 3; k++) begin
            sum3_s[c] = sum3_s[c] + SW'(tap_r[0][k][c*COLOR_DEPTH +: COLOR_DEPTH]);
         end
      end
   end

   // Stage 3: register sums and the unfiltered pixel.
   always_ff @(posedge pix_clk or negedge rstn) begin
      if (!rstn) begin
         for (int c = 0; c < CHANNELS; c++) begin
            sum9_r[c] <= '0;
            sum3_r[c] <= '0;
         end
         byp_3_r  <= '0;
         mode_3_r <= 2'b00;
         sync_3_r <= 3'b000;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            sum9_r[c] <= sum9_s[c];
            sum3_r[c] <= sum3_s[c];
         end
         byp_3_r  <= tap_r[0][0];
         mode_3_r <= mode_2_r;
         sync_3_r <= sync_2_r;
      end
   end

   // Mode mux: x/3 ~ x*171>>9, x/9 ~ x*57>>9; reserved mode falls back to bypass.
   always_comb begin
      filt_s = byp_3_r;
      for (int c = 0; c < CHANNELS; c++) begin
         case (mode_3_r)
            MODE_H3: filt_s[c*COLOR_DEPTH +: COLOR_DEPTH] = mean_scale(sum3_r[c], 8'd171);
            MODE_B9: filt_s[c*COLOR_DEPTH +: COLOR_DEPTH] = mean_scale(sum9_r[c], 8'd57);
            default: filt_s[c*COLOR_DEPTH +: COLOR_DEPTH] = byp_3_r[c*COLOR_DEPTH +: COLOR_DEPTH];
         endcase
      end
   end

   // Stage 4: output register; blanking forces the pixel to zero.
   always_ff @(posedge pix_clk or negedge rstn) begin
      if (!rstn) begin
         pixel_out <= '0;
         vs_out    <= 1'b0;
         hs_out    <= 1'b0;
         de_out    <= 1'b0;
      end else begin
         pixel_out <= sync_3_r[0] ? filt_s : '0;
         vs_out    <= sync_3_r[2];
         hs_out    <= sync_3_r[1];
         de_out    <= sync_3_r[0];
      end
   end

endmodule
